// File: rtl/i2s_out_scheduler_pkg.sv
// Shared constants and types for the codec line-out scheduler.
package i2s_out_scheduler_pkg;

    localparam int unsigned SYNTH_WIDTH  = 24;
    localparam int unsigned FRAME_CYCLES = 768;

    typedef logic [SYNTH_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/i2s_out_scheduler_if.sv
// Source-side handshake and codec-side sample bus of the line-out scheduler.
interface i2s_out_scheduler_if
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned UNDERRUN_W = 16
);
    import i2s_out_scheduler_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]                  src_valid_in;
    logic [NUM_SRC-1:0][SYNTH_WIDTH-1:0] src_sample_in;
    logic [NUM_SRC-1:0]                  src_ready_out;
    logic                                codec_valid_out;
    logic [SYNTH_WIDTH-1:0]              codec_sample_out;
    logic                                frame_tick_out;
    logic [IDX_W-1:0]                    grant_out;
    logic [UNDERRUN_W-1:0]               underrun_count_out;

    // Scheduler side
    modport master (
        input  src_valid_in,
        input  src_sample_in,
        output src_ready_out,
        output codec_valid_out,
        output codec_sample_out,
        output frame_tick_out,
        output grant_out,
        output underrun_count_out
    );

    // Producer / transmitter side
    modport slave (
        output src_valid_in,
        output src_sample_in,
        input  src_ready_out,
        input  codec_valid_out,
        input  codec_sample_out,
        input  frame_tick_out,
        input  grant_out,
        input  underrun_count_out
    );

endinterface

// File: rtl/i2s_out_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts after ptr_i.
module rr_arbiter
#(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] gnt_c
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin : search
        gnt_c = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            idx = IDX_W'((32'(ptr_i) + i) % NUM_SRC);
            if (!found && req_i[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_out_scheduler.sv
// Frame timebase plus per-frame round-robin source selection for the codec
// line-out path, with priming, underrun handling and graceful stop.
module i2s_out_scheduler
#(
    parameter int unsigned NUM_SRC          = 4,
    parameter int unsigned FRAME_CYCLES     = i2s_out_scheduler_pkg::FRAME_CYCLES,
    parameter bit          HOLD_ON_UNDERRUN = 1'b1,
    parameter int unsigned UNDERRUN_W       = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    i2s_out_scheduler_if.master   bus
);
    import i2s_out_scheduler_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

    sched_state_t          state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic                  tick_q, tick_d;
    logic                  valid_q, valid_d;
    sample_t               sample_q, sample_d;
    logic [UNDERRUN_W-1:0] urun_q, urun_d;

    logic                  arb_en_c;
    logic                  has_win_c;
    logic [NUM_SRC-1:0]    gnt_c;
    logic [NUM_SRC-1:0]    ready_c;
    logic [IDX_W-1:0]      win_idx_c;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req_i (bus.src_valid_in),
        .ptr_i (ptr_q),
        .gnt_c (gnt_c)
    );

    // Grants are only offered on a tick while priming (and enabled) or running.
    always_comb begin : arb_gate
        arb_en_c  = tick_q && (((state_q == PRIME) && enable_in) || (state_q == RUN));
        ready_c   = arb_en_c ? gnt_c : '0;
        has_win_c = |ready_c;
        win_idx_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ready_c[i]) begin
                win_idx_c = IDX_W'(i);
            end
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        sample_d = sample_q;
        urun_d   = urun_q;

        unique case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!enable_in) begin
                    state_d = IDLE;
                end else if (has_win_c) begin
                    sample_d = bus.src_sample_in[win_idx_c];
                    grant_d  = win_idx_c;
                    ptr_d    = win_idx_c;
                    valid_d  = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (tick_q) begin
                    if (has_win_c) begin
                        sample_d = bus.src_sample_in[win_idx_c];
                        grant_d  = win_idx_c;
                        ptr_d    = win_idx_c;
                    end else begin
                        if (!HOLD_ON_UNDERRUN) begin
                            sample_d = '0;
                        end
                        if (!(&urun_q)) begin
                            urun_d = urun_q + UNDERRUN_W'(1);
                        end
                    end
                end
                if (!enable_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tick_q) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    sample_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter is parked at 0 in IDLE and restarts at 0 on leaving it.
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            count_d = '0;
        end else begin
            count_d = (count_q == LAST_CNT) ? '0 : count_q + CNT_W'(1);
        end

        tick_d = (count_d == LAST_CNT) && (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin : regs
        if (rst_in) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            tick_q   <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            urun_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            tick_q   <= tick_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            urun_q   <= urun_d;
        end
    end

    assign bus.src_ready_out      = ready_c;
    assign bus.codec_valid_out    = valid_q;
    assign bus.codec_sample_out   = sample_q;
    assign bus.frame_tick_out     = tick_q;
    assign bus.grant_out          = grant_q;
    assign bus.underrun_count_out = urun_q;

endmodule

// File: tb/tb_i2s_out_scheduler.sv
// Scoreboard bench: two schedulers (hold/16-bit counter and zero/2-bit counter)
// share one stimulus; expected per-frame responses are queued and checked by a monitor.
module tb_i2s_out_scheduler;
    import i2s_out_scheduler_pkg::*;

    localparam int unsigned NS = 4;

    typedef struct {
        logic [NS-1:0] ready;
        logic          valid;
        logic [23:0]   sample_a;
        logic [23:0]   sample_b;
        logic [1:0]    grant;
        logic [15:0]   urun_a;
        logic [1:0]    urun_b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    i2s_out_scheduler_if #(.NUM_SRC(NS), .UNDERRUN_W(16)) bus_a ();
    i2s_out_scheduler_if #(.NUM_SRC(NS), .UNDERRUN_W(2))  bus_b ();

    assign bus_b.src_valid_in  = bus_a.src_valid_in;
    assign bus_b.src_sample_in = bus_a.src_sample_in;

    i2s_out_scheduler #(
        .NUM_SRC(NS), .FRAME_CYCLES(768), .HOLD_ON_UNDERRUN(1'b1), .UNDERRUN_W(16)
    ) dut_a (
        .clk_in(clk), .rst_in(rst), .enable_in(enable), .bus(bus_a.master)
    );

    i2s_out_scheduler #(
        .NUM_SRC(NS), .FRAME_CYCLES(768), .HOLD_ON_UNDERRUN(1'b0), .UNDERRUN_W(2)
    ) dut_b (
        .clk_in(clk), .rst_in(rst), .enable_in(enable), .bus(bus_b.master)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] r, input logic v, input logic [23:0] sa,
                        input logic [23:0] sb, input logic [1:0] g,
                        input logic [15:0] ua, input logic [1:0] ub);
        exp_t e;
        e.ready = r; e.valid = v; e.sample_a = sa; e.sample_b = sb;
        e.grant = g; e.urun_a = ua; e.urun_b = ub;
        sb_q.push_back(e);
    endtask

    // Wait for a tick (bounded), then return just after the commit edge.
    task automatic wait_tick(output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            seen = bus_a.frame_tick_out;
        end
        chk("tick_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready_a"},  32'(bus_a.src_ready_out),      32'd0);
        chk({tag, "_valid_a"},  32'(bus_a.codec_valid_out),    32'd0);
        chk({tag, "_sample_a"}, 32'(bus_a.codec_sample_out),   32'd0);
        chk({tag, "_tick_a"},   32'(bus_a.frame_tick_out),     32'd0);
        chk({tag, "_grant_a"},  32'(bus_a.grant_out),          32'd0);
        chk({tag, "_urun_a"},   32'(bus_a.underrun_count_out), 32'd0);
        chk({tag, "_ready_b"},  32'(bus_b.src_ready_out),      32'd0);
        chk({tag, "_valid_b"},  32'(bus_b.codec_valid_out),    32'd0);
        chk({tag, "_sample_b"}, 32'(bus_b.codec_sample_out),   32'd0);
        chk({tag, "_urun_b"},   32'(bus_b.underrun_count_out), 32'd0);
    endtask

    // Monitor: ready checked on each tick, committed outputs on the following cycle.
    initial begin : monitor
        exp_t cur;
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("commit_valid_a",  32'(bus_a.codec_valid_out),    32'(cur.valid));
                    chk("commit_valid_b",  32'(bus_b.codec_valid_out),    32'(cur.valid));
                    chk("commit_sample_a", 32'(bus_a.codec_sample_out),   32'(cur.sample_a));
                    chk("commit_sample_b", 32'(bus_b.codec_sample_out),   32'(cur.sample_b));
                    chk("commit_urun_a",   32'(bus_a.underrun_count_out), 32'(cur.urun_a));
                    chk("commit_urun_b",   32'(bus_b.underrun_count_out), 32'(cur.urun_b));
                    if (cur.valid) begin
                        chk("commit_grant_a", 32'(bus_a.grant_out), 32'(cur.grant));
                        chk("commit_grant_b", 32'(bus_b.grant_out), 32'(cur.grant));
                    end
                    pend = 1'b0;
                end
                if (bus_a.frame_tick_out) begin
                    chk("tick_b", 32'(bus_b.frame_tick_out), 32'd1);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_tick", 32'd1, 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("tick_ready_a", 32'(bus_a.src_ready_out), 32'(cur.ready));
                        chk("tick_ready_b", 32'(bus_b.src_ready_out), 32'(cur.ready));
                        pend = 1'b1;
                    end
                end else begin
                    chk("idle_ready_a", 32'(bus_a.src_ready_out), 32'd0);
                    chk("idle_ready_b", 32'(bus_b.src_ready_out), 32'd0);
                    chk("idle_tick_b",  32'(bus_b.frame_tick_out), 32'd0);
                end
            end
        end
    end

    initial begin : stim
        int cyc;
        int nt;
        logic [1:0] rr_seq [8];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

        rst = 1'b1;
        enable = 1'b0;
        bus_a.src_valid_in  = '0;
        bus_a.src_sample_in = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // First commit from src0 after a full priming frame
        bus_a.src_sample_in[0] = 24'h123456;
        bus_a.src_sample_in[1] = 24'h0000aa;
        bus_a.src_valid_in     = 4'b0001;
        @(negedge clk);
        enable = 1'b1;
        push(4'b0001, 1'b1, 24'h123456, 24'h123456, 2'd0, 16'd0, 2'd0);
        wait_tick(cyc);
        chk("prime_latency", 32'(cyc), 32'd768);

        // Park the pointer on src3 so the all-valid sequence starts at 0
        bus_a.src_sample_in[0] = 24'h000001;
        bus_a.src_sample_in[1] = 24'h000002;
        bus_a.src_sample_in[2] = 24'h000003;
        bus_a.src_sample_in[3] = 24'h000004;
        bus_a.src_valid_in     = 4'b1000;
        push(4'b1000, 1'b1, 24'h000004, 24'h000004, 2'd3, 16'd0, 2'd0);
        wait_tick(cyc);

        bus_a.src_valid_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            push(4'(1 << rr_seq[i]), 1'b1, 24'(rr_seq[i]) + 24'd1, 24'(rr_seq[i]) + 24'd1,
                 rr_seq[i], 16'd0, 2'd0);
            wait_tick(cyc);
        end

        // Three underrun frames: hold vs zero
        bus_a.src_valid_in = 4'b0000;
        push(4'b0000, 1'b1, 24'h000004, 24'h0, 2'd3, 16'd1, 2'd1); wait_tick(cyc);
        push(4'b0000, 1'b1, 24'h000004, 24'h0, 2'd3, 16'd2, 2'd2); wait_tick(cyc);
        push(4'b0000, 1'b1, 24'h000004, 24'h0, 2'd3, 16'd3, 2'd3); wait_tick(cyc);

        bus_a.src_valid_in = 4'b0100;
        push(4'b0100, 1'b1, 24'h000003, 24'h000003, 2'd2, 16'd3, 2'd3); wait_tick(cyc);

        // Narrow counter saturates at 3 while the wide one keeps counting
        bus_a.src_valid_in = 4'b0000;
        push(4'b0000, 1'b1, 24'h000003, 24'h0, 2'd2, 16'd4, 2'd3); wait_tick(cyc);
        push(4'b0000, 1'b1, 24'h000003, 24'h0, 2'd2, 16'd5, 2'd3); wait_tick(cyc);

        bus_a.src_valid_in = 4'b1111;
        push(4'b1000, 1'b1, 24'h000004, 24'h000004, 2'd3, 16'd5, 2'd3); wait_tick(cyc);

        // Stop mid-frame: drain to the next tick, then idle
        repeat (300) @(posedge clk);
        #1;
        enable = 1'b0;
        push(4'b0000, 1'b0, 24'h0, 24'h0, 2'd0, 16'd5, 2'd3);
        wait_tick(cyc);
        nt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus_a.frame_tick_out || bus_b.frame_tick_out) nt++;
        end
        chk("idle_no_tick", 32'(nt), 32'd0);
        chk("idle_valid_a", 32'(bus_a.codec_valid_out), 32'd0);

        // Re-enable: counter restarted from 0, underrun count survives IDLE
        @(negedge clk);
        enable = 1'b1;
        push(4'b0001, 1'b1, 24'h000001, 24'h000001, 2'd0, 16'd5, 2'd3);
        wait_tick(cyc);
        chk("reprime_latency", 32'(cyc), 32'd768);

        // Asynchronous reset between edges at count 500
        repeat (500) @(posedge clk);
        #3;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_zero("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(4'b0010, 1'b1, 24'h000002, 24'h000002, 2'd1, 16'd0, 2'd0);
        wait_tick(cyc);
        chk("post_rst_latency", 32'(cyc), 32'd768);

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_out_scheduler.md
Name: i2s_out_scheduler

Overview:
Shares the single codec line-out sample path between NUM_SRC sample producers (synth voices, line-in loopback, test tone). Generates the 48 kHz frame timebase from the 36.864 MHz system clock (768 cycles per frame). Selects exactly one source per frame by round-robin and presents a sample to the I2S transmitter that stays stable for the whole frame. Handles start-up priming, underrun and graceful stop.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
FRAME_CYCLES, 768, clk_in cycles per audio frame (package constant default)
HOLD_ON_UNDERRUN, 1, 1 = repeat last sample on underrun; 0 = output zero
UNDERRUN_W, 16, width of the saturating underrun counter

Ports:
clk_in  input  1  system clock, 36.864 MHz; one clock domain
rst_in  input  1  asynchronous active-high reset
enable_in  input  1  level; run request from control logic
src_valid_in  input  NUM_SRC  per-source sample available
src_sample_in  input  NUM_SRC x SYNTH_WIDTH  per-source sample, two's complement
src_ready_out  output  NUM_SRC  one-hot, one-cycle accept strobe
codec_valid_out  output  1  high while a committed sample is being streamed
codec_sample_out  output  SYNTH_WIDTH  sample for the I2S transmitter, stable per frame
frame_tick_out  output  1  one-cycle pulse at the last cycle of each frame
grant_out  output  $clog2(NUM_SRC)  index of the source that supplied the current sample
underrun_count_out  output  UNDERRUN_W  saturating count of frames with no valid source

Behaviour:
- Reset (async, any time): state IDLE, frame counter 0, rr pointer 0. All outputs 0. Takes effect mid-frame without waiting for the boundary.
- Frame counter: counts 0..FRAME_CYCLES-1 and wraps. Counts only when state != IDLE; held at 0 in IDLE. frame_tick_out = (count == FRAME_CYCLES-1) && state != IDLE.
- Arbitration happens only on a tick cycle:
  - Request vector = src_valid_in.
  - Round-robin search starts at the index after the last granted source, wrapping at NUM_SRC.
  - The winner gets src_ready_out[winner] = 1 for that single cycle. The transfer completes in the same cycle (valid && ready).
  - src_ready_out is 0 on every non-tick cycle and when no source is valid.
- Commit: on the cycle after the tick, codec_sample_out and grant_out update to the winner's sample and index. Latency tick -> output = 1 cycle. The rr pointer advances to the winner.
- States:
  - IDLE: enable_in=1 -> PRIME next cycle. The counter starts at 0.
  - PRIME: at a tick with a winner, commit -> RUN and codec_valid_out=1 from the commit cycle. At a tick with no winner, stay in PRIME with no underrun count. enable_in=0 -> IDLE.
  - RUN: at each tick with a winner, commit. At a tick with no winner, it is an underrun:
    - codec_sample_out holds its value (HOLD_ON_UNDERRUN=1) or becomes 0 (HOLD_ON_UNDERRUN=0).
    - grant_out is unchanged.
    - underrun_count_out increments, saturating at all-ones.
    - The rr pointer is unchanged.
    enable_in=0 -> DRAIN.
  - DRAIN: no new grants. At the next tick -> IDLE, codec_valid_out=0, codec_sample_out=0. enable_in re-asserted during DRAIN is ignored until IDLE is reached.
- Simultaneous events:
  - enable_in falling on a tick cycle in RUN: that tick's grant still completes, then DRAIN.
  - src_valid_in dropping on a non-tick cycle has no effect.
- underrun_count_out is cleared only by reset, not by IDLE.
- Width rules: samples pass through unmodified, with no mixing or scaling. grant_out is zero-extended and meaningful only while codec_valid_out=1.

Decomposition:
- constants package gains FRAME_CYCLES = 768 and a typedef sched_state_t {IDLE, PRIME, RUN, DRAIN}. It already holds SYNTH_WIDTH = 24.
- One sub-module, rr_arbiter: combinational one-hot grant from a request vector and pointer, parameterised on NUM_SRC. Pointer update stays in the parent.

Test Plan:
1. Reset then enable_in=1 with src0 valid, sample 24'h123456 -> first tick at cycle 767 after PRIME entry; src_ready_out=4'b0001 for 1 cycle; next cycle codec_sample_out=24'h123456, grant_out=0, codec_valid_out=1.
2. All 4 sources continuously valid with samples 24'h000001..24'h000004 -> grants over 8 frames are 0,1,2,3,0,1,2,3; exactly one ready pulse per frame.
3. In RUN, all valid low for 3 frames: HOLD_ON_UNDERRUN=1 -> sample held and underrun_count_out=3. Rerun with HOLD_ON_UNDERRUN=0 -> codec_sample_out=0. Then only src2 valid -> grant 2.
4. Saturation: force underruns past 2^UNDERRUN_W-1 (use UNDERRUN_W=2) -> counter sticks at 3.
5. Drop enable_in mid-frame at count 300 -> no further ready pulses; at the next tick codec_valid_out falls and sample=0; the counter holds 0 in IDLE.
6. Assert rst_in asynchronously at count 500 in RUN, between clock edges -> all outputs 0 immediately; after release, PRIME needs enable and a full frame before the first grant.
